regfile_port_sequencer: RTL and testbench
=========================================

Name: regfile_port_sequencer

Overview:
- Time-multiplexes one single-ported, synchronous-read register file between two clients: decode, which needs two source operands (rs1, rs2) per instruction, and writeback, which needs one write (rd).
- Sequences the two reads as back-to-back port slots.
- Gives writes priority, with a bounded starvation guard for reads.
- Bypasses a write that lands between the rs1 read and the end of the read transaction into the captured rs1 value.
- Sits between the decode/writeback stages and the register file instance.

Parameters:
W, 32, register data width
A, 5, register address width (2^A registers, register 0 reads as zero)
MAX_DEFER, 2, consecutive write-won slots tolerated while a read is pending before the read is forced through (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
rd_req_valid  in  1  decode requests an operand read
rd_req_ready  out  1  read request accepted this cycle (combinational)
rd_rs1  in  A  first source register address
rd_rs2  in  A  second source register address
rd_resp_valid  out  1  one-cycle pulse: operand data valid (registered)
rd_rs1_data  out  W  rs1 value (registered, held until next response)
rd_rs2_data  out  W  rs2 value (registered, held until next response)
wr_valid  in  1  writeback requests a write
wr_ready  out  1  write performed this cycle (combinational)
wr_addr  in  A  destination register
wr_data  in  W  write data
rf_write_enable  out  1  register file write enable (combinational)
rf_addr  out  A  register file address (combinational)
rf_write_data  out  W  register file write data (combinational)
rf_read_data  in  W  register file output; reflects the address/write from the previous clock edge

Behaviour:
- Register file contract: sampled at posedge. rf_read_data in cycle N+1 is the value at rf_addr in cycle N, or the written data if it was a write (write-through). Address 0 always reads 0.
- Port slot: one per cycle, either a write or a read issue.
- Write slot: rf_write_enable=1, rf_addr=wr_addr, rf_write_data=wr_data, wr_ready=1.
- Otherwise rf_write_enable=0. rf_addr=0 unless a read issue is in progress.
- FSM states: IDLE, RD2, RD2_WAIT, FIN.
- IDLE:
  - Write wins if wr_valid and defer_cnt<MAX_DEFER.
  - Else if rd_req_valid: rd_req_ready=1, latch rs1/rs2, rf_addr=rd_rs1, go to RD2.
- RD2 (rs1 data on rf_read_data):
  - Always capture rs1_q<=rf_read_data.
  - If a write wins: go to RD2_WAIT.
  - Else: rf_addr=rs2_q, go to FIN.
- RD2_WAIT: same decision as RD2, but no capture.
- FIN:
  - rd_rs2_data<=rf_read_data, rd_rs1_data<=rs1_q, rd_resp_valid<=1 (asserted the next cycle), go to IDLE.
  - A write may take the FIN slot. rd_req_ready=0 in FIN.
- Bypass: a write performed in RD2 or RD2_WAIT with wr_addr==rs1_q_addr and wr_addr!=0 overrides the rs1_q capture with wr_data. rs2 needs no bypass; the port reads it after the write.
- Ordering: a read is ordered after all writes performed before its FIN cycle. A FIN-cycle write is ordered after the read and is not bypassed.
- defer_cnt:
  - Increments when a write wins while a read is pending: rd_req_valid in IDLE, or state RD2/RD2_WAIT.
  - Clears whenever a read takes a slot.
  - At MAX_DEFER, wr_ready=0 and the read takes the slot.
- Latency: no contention gives rd_resp_valid 3 cycles after the rd_req_ready cycle. Each write-won slot adds 1 cycle. Throughput is at most 1 read per 3 cycles.
- Writes to register 0 are performed (register file ignores them), wr_ready=1, no bypass.
- No backpressure on responses.
- Reset:
  - State IDLE, defer_cnt=0, rd_resp_valid=0, rd_rs1_data=rd_rs2_data=0.
  - While reset is high, rd_req_ready=wr_ready=rf_write_enable=0 and rf_addr=0.
  - A reset mid-transaction drops the read with no response. Register file contents are untouched.

Test Plan:
- Write r5=55 (wr_ready same cycle), then read rs1=5, rs2=0 with no writes -> rd_resp_valid exactly 3 cycles after accept, rs1=55, rs2=0.
- Read rs1=3, rs2=4 (r3=30, r4=40), with wr_valid r3=99 asserted in the RD2 cycle -> write performed, response 4 cycles after accept, rs1=99 (bypass), rs2=40.
- Same read, write r4=77 during RD2 -> rs1=30, rs2=77. Write r4=88 during FIN -> rs2=40, and a later read returns 88.
- wr_valid held high continuously with rd_req_valid pending, MAX_DEFER=2 -> two writes, then wr_ready=0 for one cycle and rd_req_ready=1. Response still arrives; no deadlock.
- Write r0=123, then read rs1=0, rs2=0 -> both 0, no bypass.
- Assert reset in the RD2 cycle -> no rd_resp_valid; next cycle outputs are at reset values; a fresh read of r5 returns 55.

Source files
------------

// File: rtl/regfile_port_sequencer.sv
// Shares one synchronous-read register file port between decode (two reads per request)
// and writeback (one write), with write priority, a read starvation guard and rs1 bypass.
module regfile_port_sequencer #(
  parameter int W         = 32,
  parameter int A         = 5,
  parameter int MAX_DEFER = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd_req_valid,
  output logic         rd_req_ready,
  input  logic [A-1:0] rd_rs1,
  input  logic [A-1:0] rd_rs2,
  output logic         rd_resp_valid,
  output logic [W-1:0] rd_rs1_data,
  output logic [W-1:0] rd_rs2_data,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [A-1:0] wr_addr,
  input  logic [W-1:0] wr_data,
  output logic         rf_write_enable,
  output logic [A-1:0] rf_addr,
  output logic [W-1:0] rf_write_data,
  input  logic [W-1:0] rf_read_data
);

  localparam int DW = $clog2(MAX_DEFER + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD2,
    S_RD2_WAIT,
    S_FIN
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [A-1:0]   r_rs1_addr;
  logic [A-1:0]   r_rs2_addr;
  logic [W-1:0]   r_rs1_q;
  logic [DW-1:0]  r_defer_cnt;

  logic w_write_ok;
  logic w_wr_go;
  logic w_accept;
  logic w_issue_rs2;
  logic w_read_pending;
  logic w_in_rd2;
  logic w_bypass;

  // A write may only win the slot while the pending read has not been deferred too often.
  assign w_write_ok = wr_valid && (r_defer_cnt < DW'(MAX_DEFER));
  assign w_in_rd2   = (r_state == S_RD2) || (r_state == S_RD2_WAIT);

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    w_state_nxt     = r_state;
    w_wr_go         = 1'b0;
    w_accept        = 1'b0;
    w_issue_rs2     = 1'b0;
    rd_req_ready    = 1'b0;
    wr_ready        = 1'b0;
    rf_write_enable = 1'b0;
    rf_addr         = '0;
    rf_write_data   = '0;

    if (!reset) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_write_ok) begin
            w_wr_go = 1'b1;
          end else if (rd_req_valid) begin
            w_accept     = 1'b1;
            rd_req_ready = 1'b1;
            rf_addr      = rd_rs1;
            w_state_nxt  = S_RD2;
          end
        end
        S_RD2, S_RD2_WAIT: begin
          if (w_write_ok) begin
            w_wr_go     = 1'b1;
            w_state_nxt = S_RD2_WAIT;
          end else begin
            w_issue_rs2 = 1'b1;
            rf_addr     = r_rs2_addr;
            w_state_nxt = S_FIN;
          end
        end
        S_FIN: begin
          // The FIN slot is free: rs2 is already in flight, so any write may take it.
          w_wr_go     = wr_valid;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase

      if (w_wr_go) begin
        wr_ready        = 1'b1;
        rf_write_enable = 1'b1;
        rf_addr         = wr_addr;
        rf_write_data   = wr_data;
      end
    end
  end

  assign w_read_pending = ((r_state == S_IDLE) && rd_req_valid) || w_in_rd2;
  assign w_bypass       = w_wr_go && w_in_rd2 && (wr_addr == r_rs1_addr) && (wr_addr != '0);

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_defer_cnt   <= '0;
      rd_resp_valid <= 1'b0;
      rd_rs1_data   <= '0;
      rd_rs2_data   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      rd_resp_valid <= (r_state == S_FIN);
      if (r_state == S_FIN) begin
        rd_rs1_data <= r_rs1_q;
        rd_rs2_data <= rf_read_data;
      end
      if (w_accept || w_issue_rs2) begin
        r_defer_cnt <= '0;
      end else if (w_wr_go && w_read_pending) begin
        r_defer_cnt <= r_defer_cnt + DW'(1);
      end
    end
  end

  // NOTE: operand latches carry no reset; they are always written before any use.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rs1_addr <= rd_rs1;
      r_rs2_addr <= rd_rs2;
    end
    if (w_bypass) begin
      r_rs1_q <= wr_data;
    end else if (r_state == S_RD2) begin
      r_rs1_q <= rf_read_data;
    end
  end

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Bench for regfile_port_sequencer: directed scenarios plus random traffic checked
// against a transaction-level register-state scoreboard.
module tb_regfile_port_sequencer;

  localparam int W         = 32;
  localparam int A         = 5;
  localparam int MAX_DEFER = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rd_req_valid = 1'b0;
  logic         rd_req_ready;
  logic [A-1:0] rd_rs1 = '0;
  logic [A-1:0] rd_rs2 = '0;
  logic         rd_resp_valid;
  logic [W-1:0] rd_rs1_data;
  logic [W-1:0] rd_rs2_data;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [A-1:0] wr_addr = '0;
  logic [W-1:0] wr_data = '0;
  logic         rf_write_enable;
  logic [A-1:0] rf_addr;
  logic [W-1:0] rf_write_data;
  logic [W-1:0] rf_read_data = '0;

  regfile_port_sequencer #(.W(W), .A(A), .MAX_DEFER(MAX_DEFER)) dut (
    .clk             (clk),
    .reset           (reset),
    .rd_req_valid    (rd_req_valid),
    .rd_req_ready    (rd_req_ready),
    .rd_rs1          (rd_rs1),
    .rd_rs2          (rd_rs2),
    .rd_resp_valid   (rd_resp_valid),
    .rd_rs1_data     (rd_rs1_data),
    .rd_rs2_data     (rd_rs2_data),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .rf_write_enable (rf_write_enable),
    .rf_addr         (rf_addr),
    .rf_write_data   (rf_write_data),
    .rf_read_data    (rf_read_data)
  );

  always #5 clk = ~clk;

  // Register file: synchronous read, write-through, register 0 hard-wired to zero.
  logic [W-1:0] rf_mem [2**A];
  initial for (int i = 0; i < 2**A; i++) rf_mem[i] = '0;
  always @(posedge clk) begin
    if (rf_write_enable) rf_mem[rf_addr] <= rf_write_data;
    rf_read_data <= (rf_addr == '0) ? '0 : (rf_write_enable ? rf_write_data : rf_mem[rf_addr]);
  end

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: architectural register state as written by accepted writes. A response
  // must show the state before the FIN cycle (the cycle preceding rd_resp_valid).
  logic [W-1:0] arch [2**A];
  logic [W-1:0] snap [2**A];
  initial for (int i = 0; i < 2**A; i++) begin arch[i] = '0; snap[i] = '0; end

  bit           outst;
  bit           prev_wr;
  int           cyc, acc_cyc, wr_during, idle_run, nw;
  logic [A-1:0] m_a1, m_a2;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      check("rst_rd_ready", rd_req_ready, 0);
      check("rst_wr_ready", wr_ready, 0);
      check("rst_we", rf_write_enable, 0);
      check("rst_addr", rf_addr, 0);
      outst    = 0;
      prev_wr  = 0;
      idle_run = 0;
      snap     = arch;
    end else begin
      if (rd_resp_valid) begin
        if (!outst) begin
          check("resp_unexpected", 1, 0);
        end else begin
          nw = wr_during - (prev_wr ? 1 : 0);
          check("sb_rs1", rd_rs1_data, snap[m_a1]);
          check("sb_rs2", rd_rs2_data, snap[m_a2]);
          check("sb_latency", cyc - acc_cyc, 3 + nw);
          if (nw > MAX_DEFER) check("sb_defer_rd2", nw, MAX_DEFER);
          outst = 0;
        end
      end
      if (outst) check("sb_busy_ready", rd_req_ready, 0);
      if (rd_req_valid && !outst && !wr_ready) check("sb_rd_slot", rd_req_ready, 1);
      if (wr_valid && !outst && !rd_req_valid) check("sb_wr_free", wr_ready, 1);
      check("sb_we", rf_write_enable, wr_ready);
      if (wr_ready) begin
        check("sb_wr_valid", wr_valid, 1);
        check("sb_rf_addr", rf_addr, wr_addr);
        check("sb_rf_wdata", rf_write_data, wr_data);
      end
      if (!outst && rd_req_valid && wr_ready) begin
        idle_run++;
        if (idle_run > MAX_DEFER) check("sb_defer_idle", idle_run, MAX_DEFER);
      end else begin
        idle_run = 0;
      end
      if (rd_req_valid && rd_req_ready) begin
        outst     = 1;
        acc_cyc   = cyc;
        m_a1      = rd_rs1;
        m_a2      = rd_rs2;
        wr_during = 0;
      end
      snap = arch;
      if (wr_valid && wr_ready && wr_addr != '0) arch[wr_addr] = wr_data;
      prev_wr = 0;
      if (outst && wr_ready) begin
        wr_during++;
        prev_wr = 1;
      end
    end
  end

  task automatic do_write(input logic [A-1:0] a, input logic [W-1:0] d);
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    check("wr_same_cycle", wr_ready, 1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  // One read; optionally a single write pulse wr_at cycles after the accept cycle.
  task automatic read_txn(input string tag, input logic [A-1:0] a1, input logic [A-1:0] a2,
                          input int wr_at, input logic [A-1:0] wa, input logic [W-1:0] wd,
                          input logic [W-1:0] e1, input logic [W-1:0] e2, input int elat);
    bit got_resp = 0;
    @(posedge clk); #1;
    rd_req_valid = 1'b1; rd_rs1 = a1; rd_rs2 = a2;
    @(negedge clk);
    check({tag, "_accept"}, rd_req_ready, 1);
    for (int k = 1; k <= 12 && !got_resp; k++) begin
      @(posedge clk); #1;
      rd_req_valid = 1'b0;
      wr_valid = (k == wr_at); wr_addr = wa; wr_data = wd;
      @(negedge clk);
      if (wr_valid) check({tag, "_wr"}, wr_ready, 1);
      if (rd_resp_valid) begin
        got_resp = 1;
        check({tag, "_latency"}, k, elat);
        check({tag, "_rs1"}, rd_rs1_data, e1);
        check({tag, "_rs2"}, rd_rs2_data, e2);
      end
    end
    if (!got_resp) check({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    logic [0:7] exp_wr_rdy;
    logic [0:7] exp_rd_rdy;
    exp_wr_rdy = 8'b1101_1011;
    exp_rd_rdy = 8'b0010_0000;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_resp_valid", rd_resp_valid, 0);
    check("reset_rs1_data", rd_rs1_data, 0);
    check("reset_rs2_data", rd_rs2_data, 0);

    do_write(5, 55);
    read_txn("plain", 5, 0, -1, 0, 0, 55, 0, 3);

    do_write(3, 30);
    do_write(4, 40);
    read_txn("bypass", 3, 4, 1, 3, 99, 99, 40, 4);
    do_write(3, 30);
    read_txn("rs2_after_wr", 3, 4, 1, 4, 77, 30, 77, 4);
    do_write(4, 40);
    read_txn("fin_wr", 3, 4, 2, 4, 88, 30, 40, 3);
    read_txn("fin_wr_later", 4, 4, -1, 0, 0, 88, 88, 3);

    // Writes held high against a pending read: the guard must force the read through.
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_addr = 10; wr_data = 1000;
    rd_req_valid = 1'b1; rd_rs1 = 10; rd_rs2 = 11;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("starve_wr_ready_%0d", c), wr_ready, exp_wr_rdy[c]);
      check($sformatf("starve_rd_ready_%0d", c), rd_req_ready, exp_rd_rdy[c]);
      check($sformatf("starve_resp_%0d", c), rd_resp_valid, (c == 7));
      if (c == 7) begin
        check("starve_rs1", rd_rs1_data, 1004);
        check("starve_rs2", rd_rs2_data, 0);
      end
      @(posedge clk); #1;
      wr_data = 1000 + c + 1;
      if (c == 2) rd_req_valid = 1'b0;
    end
    wr_valid = 1'b0;
    repeat (2) @(posedge clk);

    do_write(0, 123);
    read_txn("zero", 0, 0, -1, 0, 0, 0, 0, 3);
    read_txn("zero_nobyp", 0, 0, 1, 0, 77, 0, 0, 4);

    // Reset in the RD2 cycle drops the read.
    @(posedge clk); #1;
    rd_req_valid = 1'b1; rd_rs1 = 5; rd_rs2 = 0;
    @(negedge clk);
    check("rst_mid_accept", rd_req_ready, 1);
    @(posedge clk); #1;
    reset = 1'b1; wr_valid = 1'b1; wr_addr = 5; wr_data = 999;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0; wr_valid = 1'b0; rd_req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_resp", rd_resp_valid, 0);
    check("rst_mid_rs1", rd_rs1_data, 0);
    check("rst_mid_rs2", rd_rs2_data, 0);
    repeat (4) begin
      @(negedge clk);
      check("rst_mid_no_resp", rd_resp_valid, 0);
    end
    read_txn("after_reset", 5, 0, -1, 0, 0, 55, 0, 3);

    // Random traffic: decode holds a request until accepted, writeback toggles freely.
    acc = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (rd_req_valid && acc) begin
        rd_req_valid = 1'b0;
      end else if (!rd_req_valid && $urandom_range(2) == 0) begin
        rd_req_valid = 1'b1;
        rd_rs1 = A'($urandom_range(7));
        rd_rs2 = A'($urandom_range(7));
      end
      wr_valid = 1'($urandom_range(1));
      wr_addr  = A'($urandom_range(7));
      wr_data  = $urandom;
      @(negedge clk);
      acc = rd_req_valid && rd_req_ready;
    end
    @(posedge clk); #1;
    rd_req_valid = 1'b0; wr_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("drain_outstanding", outst, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
